// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 Booth multiply / restoring divide with HI/LO result registers
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_next;

  // op[1] selects divide, op[0] selects the unsigned variant
  logic [1:0]     op_r;
  // Multiply: A accumulator (W+1) / divide: partial remainder (W+1)
  logic [WIDTH:0] acc;
  // Multiply: multiplier Q shifting out / divide: dividend in, quotient out
  logic [WIDTH-1:0] qreg;
  // Booth q-1 bit
  logic           q_1;
  // Multiplicand or divisor magnitude, widened by one bit
  logic [WIDTH:0] mreg;
  logic [CW-1:0]  count;
  logic           neg_q;
  logic           neg_r;

  logic             is_signed_in;
  logic             start_div_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  assign is_signed_in   = ~op[0];
  assign start_div_zero = (state == S_IDLE) && start && op[1] && (b == '0);
  assign a_mag = (is_signed_in && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed_in && b[WIDTH-1]) ? -b : b;

  // Datapath combinational helpers: one Booth step, one restoring step and the fix-up values
  always_comb begin
    booth_sum = acc;
    case ({qreg[0], q_1})
      2'b01:   booth_sum = acc + mreg;
      2'b10:   booth_sum = acc - mreg;
      default: booth_sum = acc;
    endcase
    rem_sh   = {acc[WIDTH-1:0], qreg[WIDTH-1]};
    trial    = {1'b0, rem_sh} - {1'b0, mreg};
    // For MULTU the final q-1 is b's MSB; the extra Booth step (pair 0,1) adds M at weight 2^W
    mul_hi   = acc[WIDTH-1:0] + ((op_r[0] && q_1) ? mreg[WIDTH-1:0] : '0);
    quot_fix = neg_q ? -qreg : qreg;
    rem_fix  = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (op[1] && (b == '0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN:   if (count == CW'(1)) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs decoded from state
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Operand latch, iteration, fix-up and registered done/div_zero pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_r     <= '0;
      acc      <= '0;
      qreg     <= '0;
      q_1      <= 1'b0;
      mreg     <= '0;
      count    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= (state_next == S_DONE);
      div_zero <= start_div_zero;
      case (state)
        S_IDLE: begin
          if (start && !start_div_zero) begin
            op_r  <= op;
            acc   <= '0;
            q_1   <= 1'b0;
            count <= CW'(WIDTH);
            if (op[1]) begin
              qreg  <= a_mag;
              mreg  <= {1'b0, b_mag};
              neg_q <= is_signed_in && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r <= is_signed_in && a[WIDTH-1];
            end else begin
              qreg  <= b;
              mreg  <= {(is_signed_in & a[WIDTH-1]), a};
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end
          end
        end
        S_RUN: begin
          count <= count - CW'(1);
          if (op_r[1]) begin
            if (!trial[WIDTH+1]) begin
              acc  <= trial[WIDTH:0];
              qreg <= {qreg[WIDTH-2:0], 1'b1};
            end else begin
              acc  <= rem_sh;
              qreg <= {qreg[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            qreg <= {booth_sum[0], qreg[WIDTH-1:1]};
            q_1  <= qreg[0];
          end
        end
        S_FIX: begin
          if (op_r[1]) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= mul_hi;
            lo <= qreg;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit (vectors, corner sequences, random vs model)
module tb_mult_div_unit;

  localparam int W = 32;
  localparam int NORMAL_LAT = W + 1;

  logic         clock;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int tests;
  int fails;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e_hi;
    logic [W-1:0] e_lo;
    logic         e_dz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: plain 64-bit arithmetic
  task automatic model(input logic [1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic [W-1:0] p_hi, input logic [W-1:0] p_lo,
                       output logic [W-1:0] r_hi, output logic [W-1:0] r_lo, output logic r_dz);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, prod;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ua = {32'b0, ma};
    ub = {32'b0, mb};
    r_dz = 1'b0;
    r_hi = p_hi;
    r_lo = p_lo;
    case (mop)
      2'b00: begin prod = 64'(sa * sb); r_hi = prod[63:32]; r_lo = prod[31:0]; end
      2'b01: begin prod = ua * ub; r_hi = prod[63:32]; r_lo = prod[31:0]; end
      2'b10: begin
        if (mb == 0) r_dz = 1'b1;
        else begin
          q = sa / sb; r = sa % sb;
          prod = 64'(q); r_lo = prod[31:0];
          prod = 64'(r); r_hi = prod[31:0];
        end
      end
      default: begin
        if (mb == 0) r_dz = 1'b1;
        else begin
          prod = ua / ub; r_lo = prod[31:0];
          prod = ua % ub; r_hi = prod[31:0];
        end
      end
    endcase
  endtask

  // Issue one operation, return results, done latency (edges after start edge) and busy/idle status
  task automatic run_op(input logic [1:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        output logic [W-1:0] r_hi, output logic [W-1:0] r_lo, output logic r_dz,
                        output int lat, output logic busy_ok, output logic idle_after);
    @(negedge clock);
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    @(posedge clock); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    lat = -1;
    busy_ok = 1'b1;
    r_dz = 1'b0;
    for (int e = 0; e < 100; e++) begin
      if (done) begin
        lat = e;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(posedge clock); #1;
    end
    r_hi = hi;
    r_lo = lo;
    r_dz = div_zero;
    if (!busy) busy_ok = 1'b0;
    @(posedge clock); #1;
    idle_after = !busy && !done && !div_zero;
  endtask

  vec_t vecs[13];

  initial begin
    logic [W-1:0] g_hi, g_lo, m_hi, m_lo;
    logic         g_dz, m_dz, bok, idl;
    int           lat, ndone;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;

    tests = 0;
    fails = 0;

    vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[7]  = '{2'b01, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 1'b0};
    vecs[8]  = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[9]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[10] = '{2'b11, 32'h00000005, 32'h00000007, 32'h00000005, 32'h00000000, 1'b0};
    vecs[11] = '{2'b11, 32'h00001234, 32'h00000000, 32'h00000005, 32'h00000000, 1'b1};
    vecs[12] = '{2'b10, 32'h00000009, 32'h00000000, 32'h00000005, 32'h00000000, 1'b1};

    reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_flags", {61'b0, busy, done, div_zero}, 64'h0);
    @(negedge clock);
    reset = 1'b1;

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, g_hi, g_lo, g_dz, lat, bok, idl);
      check($sformatf("vec%0d_hi", i), 64'(g_hi), 64'(vecs[i].e_hi));
      check($sformatf("vec%0d_lo", i), 64'(g_lo), 64'(vecs[i].e_lo));
      check($sformatf("vec%0d_dz", i), 64'(g_dz), 64'(vecs[i].e_dz));
      check($sformatf("vec%0d_lat", i), 64'(lat), vecs[i].e_dz ? 64'd0 : 64'(NORMAL_LAT));
      check($sformatf("vec%0d_busy", i), 64'(bok), 64'd1);
      check($sformatf("vec%0d_idle", i), 64'(idl), 64'd1);
    end

    // start pulsed during RUN is ignored: exactly one done with the first op's result
    @(negedge clock);
    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd0;
    @(negedge clock);
    start = 1'b0;
    ndone = 0;
    g_dz = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clock); #1;
      if (done) begin
        ndone++;
        g_hi = hi;
        g_lo = lo;
      end
      if (div_zero) g_dz = 1'b1;
    end
    check("busy_start_done_count", 64'(ndone), 64'd1);
    check("busy_start_hi", 64'(g_hi), 64'd0);
    check("busy_start_lo", 64'(g_lo), 64'd30);
    check("busy_start_no_dz", 64'(g_dz), 64'd0);

    // Reset mid-RUN: abandon, clear hi/lo, no done afterwards
    @(negedge clock);
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_mid_hi", 64'(hi), 64'h0);
    check("rst_mid_lo", 64'(lo), 64'h0);
    check("rst_mid_busy", 64'(busy), 64'h0);
    @(negedge clock);
    reset = 1'b1;
    ndone = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clock); #1;
      if (done || busy) ndone++;
    end
    check("rst_mid_no_done", 64'(ndone), 64'd0);
    check("rst_mid_lo_hold", 64'(lo), 64'h0);

    // Random operations against the model
    m_hi = '0;
    m_lo = '0;
    for (int n = 0; n < 1500; n++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       ra = 32'h80000000;
        1:       ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 11))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      model(rop, ra, rb, m_hi, m_lo, m_hi, m_lo, m_dz);
      run_op(rop, ra, rb, g_hi, g_lo, g_dz, lat, bok, idl);
      check($sformatf("rnd%0d_op%0d_%h_%h_hi", n, rop, ra, rb), 64'(g_hi), 64'(m_hi));
      check($sformatf("rnd%0d_op%0d_%h_%h_lo", n, rop, ra, rb), 64'(g_lo), 64'(m_lo));
      check($sformatf("rnd%0d_dz", n), 64'(g_dz), 64'(m_dz));
      check($sformatf("rnd%0d_lat", n), 64'(lat), m_dz ? 64'd0 : 64'(NORMAL_LAT));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
